// File: rtl/ula_pkg.sv
// Shared definitions for the sequential N-bit ULA: op codes, flag bit positions
// and FSM state encoding.
package ula_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/ula_comb_nb.sv
// Single-cycle part of the ULA: add, sub, and, or, not-A with carry and signed
// overflow; multi-cycle and reserved codes yield zero here.
module ula_comb_nb
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    input  logic        [2:0]       op_i,
    output logic signed [WIDTH-1:0] res_o,
    output logic                    carry_o,
    output logic                    ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             is_sub;

    always_comb begin
        is_sub  = (op_i == OP_SUB);
        b_eff   = is_sub ? ~b_i : b_i;
        sum     = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        res_o   = '0;
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        unique case (op_i)
            OP_ADD, OP_SUB: begin
                res_o   = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
                // Operands of equal sign producing a result of the other sign.
                ovf_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_NOTA: res_o = ~a_i;
            OP_MUL, OP_DIV, OP_RSVD: res_o = '0;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/ula_nb_seq_md.sv
// Clocked N-bit ULA with start/busy/done handshake: single-cycle add/sub/logic,
// WIDTH-step shift-add signed multiply and restoring signed divide.
module ula_nb_seq_md
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic        [2:0]       op,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic                    busy,
    output logic                    done,
    output logic        [WIDTH-1:0] saida,
    output logic        [WIDTH-1:0] saida_hi,
    output logic        [3:0]       flag,
    output logic                    dz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ld_imm, ld_long, step, fix, is_long;

    logic        [2:0]       op_q, op_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic        [WIDTH-1:0] mb_q, mb_d;
    logic        [WIDTH-1:0] acc_q, acc_d;
    logic        [WIDTH-1:0] sh_q, sh_d;

    logic        [WIDTH-1:0] saida_q, saida_d, hi_q, hi_d;
    logic        [3:0]       flag_q, flag_d;
    logic                    dz_q, dz_d, done_q, done_d;

    logic signed [WIDTH-1:0] c_res;
    logic                    c_carry, c_ovf;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shf;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_u, prod_s;
    logic [WIDTH-1:0]   quo, rem;
    logic               sgn_q;

    ula_comb_nb #(.WIDTH(WIDTH)) u_comb (
        .a_i     (A),
        .b_i     (B),
        .op_i    (op),
        .res_o   (c_res),
        .carry_o (c_carry),
        .ovf_o   (c_ovf)
    );

    assign is_long = (op == OP_MUL) || (op == OP_DIV);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start && is_long) state_d = ST_ITER;
            ST_ITER: if (cnt_q == LAST_STEP) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_imm  = 1'b0;
        ld_long = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ld_imm  = start && !is_long;
                ld_long = start && is_long;
            end
            ST_ITER: step = 1'b1;
            ST_FIX:  fix  = 1'b1;
            default: ;
        endcase
    end

    // Iteration datapath: {acc, sh} is the product shift pair for mul, and the
    // partial remainder / dividend-quotient pair for div.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        mb_d  = mb_q;
        acc_d = acc_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
        div_shf = {acc_q, sh_q[WIDTH-1]};
        div_sub = div_shf[WIDTH-1:0] - mb_q;
        div_ge  = (div_shf >= {1'b0, mb_q});
        if (ld_long) begin
            a_d   = A;
            b_d   = B;
            op_d  = op;
            mb_d  = mag(B);
            acc_d = '0;
            sh_d  = mag(A);
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            if (op_q == OP_MUL) begin
                acc_d = mul_sum[WIDTH:1];
                sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
            end else begin
                acc_d = div_ge ? div_sub : div_shf[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], div_ge};
            end
        end
    end

    always_comb begin
        saida_d = saida_q;
        hi_d    = hi_q;
        flag_d  = flag_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        sgn_q   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        prod_u  = {acc_q, sh_q};
        prod_s  = sgn_q ? -prod_u : prod_u;
        quo     = sgn_q ? -sh_q : sh_q;
        rem     = a_q[WIDTH-1] ? -acc_q : acc_q;
        if (ld_imm) begin
            done_d         = 1'b1;
            saida_d        = c_res;
            hi_d           = '0;
            dz_d           = 1'b0;
            flag_d         = '0;
            flag_d[FLG_C]  = c_carry;
            flag_d[FLG_V]  = c_ovf;
            flag_d[FLG_Z]  = (c_res == '0);
            flag_d[FLG_N]  = c_res[WIDTH-1];
        end else if (fix) begin
            done_d = 1'b1;
            dz_d   = 1'b0;
            flag_d = '0;
            if (op_q == OP_MUL) begin
                saida_d       = prod_s[WIDTH-1:0];
                hi_d          = prod_s[2*WIDTH-1:WIDTH];
                // Fits in WIDTH signed only if the upper half is a sign extension.
                flag_d[FLG_V] = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
                flag_d[FLG_Z] = (prod_s == '0);
                flag_d[FLG_N] = prod_s[2*WIDTH-1];
            end else if (b_q == '0) begin
                saida_d       = '1;
                hi_d          = a_q;
                dz_d          = 1'b1;
                flag_d[FLG_V] = 1'b1;
                flag_d[FLG_N] = 1'b1;
            end else begin
                saida_d       = quo;
                hi_d          = rem;
                flag_d[FLG_V] = (a_q == S_MIN) && (b_q == '1);
                flag_d[FLG_Z] = (quo == '0);
                flag_d[FLG_N] = quo[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            saida_q <= '0;
            hi_q    <= '0;
            flag_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            saida_q <= saida_d;
            hi_q    <= hi_d;
            flag_q  <= flag_d;
            dz_q    <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        op_q  <= op_d;
        mb_q  <= mb_d;
        acc_q <= acc_d;
        sh_q  <= sh_d;
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign saida    = saida_q;
    assign saida_hi = hi_q;
    assign flag     = flag_q;
    assign dz       = dz_q;

endmodule

// File: tb/tb_ula_nb_seq_md.sv
// Scoreboard bench for ula_nb_seq_md at WIDTH=8: expected results are queued at
// the start edge and compared when done pulses.
module tb_ula_nb_seq_md;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] hi;
        logic [3:0]   f;
        logic         dz;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, dz;
    logic [W-1:0] saida, saida_hi;
    logic [3:0]   flag;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t e_m;

    ula_nb_seq_md #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .saida    (saida),
        .saida_hi (saida_hi),
        .flag     (flag),
        .dz       (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int sa, sbv, r, q, rm;
        logic [W:0] s9;
        sa = $signed(a);
        sbv = $signed(b);
        e.s = '0; e.hi = '0; e.f = '0; e.dz = 1'b0; e.cyc = 0;
        case (o)
            3'b000: begin
                s9 = {1'b0, a} + {1'b0, b};
                r = sa + sbv;
                e.s = s9[W-1:0]; e.f[3] = s9[W]; e.f[2] = (r > 127) || (r < -128);
            end
            3'b100: begin
                s9 = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r = sa - sbv;
                e.s = s9[W-1:0]; e.f[3] = s9[W]; e.f[2] = (r > 127) || (r < -128);
            end
            3'b001: e.s = a & b;
            3'b010: e.s = a | b;
            3'b011: e.s = ~a;
            3'b101: begin
                r = sa * sbv;
                e.s = r[7:0]; e.hi = r[15:8];
                e.f[2] = (r > 127) || (r < -128);
                e.f[1] = (r == 0);
                e.f[0] = (r < 0);
            end
            3'b110: begin
                if (b == '0) begin
                    e.s = 8'hFF; e.hi = a; e.dz = 1'b1; e.f = 4'b0101;
                end else begin
                    q = sa / sbv;
                    rm = sa % sbv;
                    e.s = q[7:0]; e.hi = rm[7:0];
                    e.f[2] = (q > 127);
                    e.f[1] = (e.s == 0);
                    e.f[0] = e.s[7];
                end
            end
            default: e.s = '0;
        endcase
        if (o != 3'b101 && o != 3'b110) begin
            e.f[1] = (e.s == 0);
            e.f[0] = e.s[7];
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'hFF;
            3: return 8'h00;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("busy_timeout", busy, 0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_idle();
        e = model(o, a, b);
        e.cyc = cyc + 1 + ((o == 3'b101 || o == 3'b110) ? W + 1 : 0);
        sb.push_back(e);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); A = W'($urandom); B = W'($urandom);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", done, 0);
            end else begin
                e_m = sb.pop_front();
                chk("latency", cyc, e_m.cyc);
                chk("busy_at_done", busy, 0);
                chk("saida", saida, e_m.s);
                chk("saida_hi", saida_hi, e_m.hi);
                chk("flag", flag, e_m.f);
                chk("dz", dz, e_m.dz);
            end
        end
    end

    initial begin
        int g;
        // Reset held with start asserted: reset must win.
        start = 1'b1; op = 3'b000; A = 8'h7F; B = 8'h01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_saida", saida, 0);
        chk("rst_hi", saida_hi, 0);
        chk("rst_flag", flag, 0);
        chk("rst_dz", dz, 0);

        run_op(3'b000, 8'h7F, 8'h01);
        run_op(3'b100, 8'h05, 8'h05);
        run_op(3'b101, 8'hFD, 8'h05);
        run_op(3'b110, 8'hF9, 8'h02);
        run_op(3'b110, 8'h80, 8'hFF);
        run_op(3'b110, 8'h10, 8'h00);
        run_op(3'b000, 8'hFF, 8'h01);
        run_op(3'b100, 8'h00, 8'h01);
        run_op(3'b100, 8'h80, 8'h01);
        run_op(3'b001, 8'hF0, 8'h3C);
        run_op(3'b010, 8'h0F, 8'h30);
        run_op(3'b011, 8'h5A, 8'h00);
        run_op(3'b111, 8'h12, 8'h34);
        run_op(3'b101, 8'h80, 8'h80);
        run_op(3'b101, 8'h7F, 8'hFF);
        run_op(3'b101, 8'h00, 8'h9C);
        run_op(3'b110, 8'h64, 8'hF9);
        run_op(3'b110, 8'h00, 8'h05);

        // Start during iteration is ignored; the mul must finish untouched.
        run_op(3'b101, 8'h0C, 8'hF6);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b000; A = 8'h01; B = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_ignore_start", busy, 1);

        // Reset at the fourth iteration aborts the op with no done.
        wait_idle();
        start = 1'b1; op = 3'b101; A = 8'h05; B = 8'h07;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_op", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_saida", saida, 0);
        chk("abort_hi", saida_hi, 0);
        chk("abort_flag", flag, 0);
        chk("abort_dz", dz, 0);

        run_op(3'b110, 8'h80, 8'hFF);
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick());
        end

        g = 0;
        while (sb.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
